// File: rtl/controle_senha.sv
// controle_senha: access-code controller (lock, verify, open, program, lockout).
// Optional master code enabled by defining CONTROLE_SENHA_MESTRE_EN.
module controle_senha #(
    parameter int unsigned MAX_TENTATIVAS  = 3,
    parameter int unsigned ABERTO_CICLOS   = 25000000,
    parameter int unsigned BLOQUEIO_CICLOS = 50000000,
    parameter logic [15:0] SENHA_PADRAO    = 16'h0000,
    parameter logic [15:0] SENHA_MESTRE    = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] codigo,
    input  logic        salve,
    input  logic        modo_prog,
    output logic        aberto,
    output logic        bloqueado,
    output logic        erro,
    output logic        senha_gravada,
    output logic [3:0]  tentativas,
    output logic [2:0]  estado
);

    localparam int unsigned MAX_CICLOS =
        (ABERTO_CICLOS > BLOQUEIO_CICLOS) ? ABERTO_CICLOS : BLOQUEIO_CICLOS;
    localparam int TW = ($clog2(MAX_CICLOS) < 1) ? 1 : $clog2(MAX_CICLOS);
    localparam logic [TW-1:0] CARGA_ABERTO = TW'(ABERTO_CICLOS - 1);
    localparam logic [TW-1:0] CARGA_BLOQ   = TW'(BLOQUEIO_CICLOS - 1);
    localparam logic [3:0]    MAX_T        = 4'(MAX_TENTATIVAS);

`ifdef CONTROLE_SENHA_MESTRE_EN
    localparam bit MESTRE_EN = 1'b1;
`else
    localparam bit MESTRE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        TRANCADO  = 3'd0,
        VERIFICA  = 3'd1,
        ABERTO    = 3'd2,
        PROGRAMA  = 3'd3,
        BLOQUEADO = 3'd4
    } estado_t;

    estado_t        r_estado;
    logic [15:0]    r_senha;
    logic [15:0]    r_cod_lat;
    logic [3:0]     r_tent;
    logic [TW-1:0]  r_timer;
    logic           r_salve_d;
    logic           r_aberto;
    logic           r_bloq;
    logic           r_erro;
    logic           r_gravada;

    logic           w_evento;
    logic           w_expira;
    logic           w_mestre_cod;
    logic           w_mestre_blq;
    logic           w_match;
    logic [3:0]     w_tent_inc;

    assign w_evento     = salve & ~r_salve_d;
    assign w_expira     = (r_timer == '0);
    assign w_mestre_cod = MESTRE_EN && (r_cod_lat == SENHA_MESTRE);
    assign w_mestre_blq = MESTRE_EN && w_evento && (codigo == SENHA_MESTRE);
    assign w_match      = (r_cod_lat == r_senha) || w_mestre_cod;
    assign w_tent_inc   = (r_tent >= MAX_T) ? MAX_T : r_tent + 4'd1;

    // Mode sequencing, password store, attempt counter and shared timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado  <= TRANCADO;
            r_senha   <= SENHA_PADRAO;
            r_cod_lat <= '0;
            r_tent    <= '0;
            r_timer   <= '0;
            r_salve_d <= 1'b1;
            r_aberto  <= 1'b0;
            r_bloq    <= 1'b0;
            r_erro    <= 1'b0;
            r_gravada <= 1'b0;
        end else begin
            r_salve_d <= salve;
            r_erro    <= 1'b0;
            r_gravada <= 1'b0;
            if (w_evento) begin
                r_cod_lat <= codigo;
            end
            if (!w_expira) begin
                r_timer <= r_timer - 1'b1;
            end
            unique case (r_estado)
                TRANCADO: begin
                    if (w_evento) begin
                        r_estado <= VERIFICA;
                    end
                end
                VERIFICA: begin
                    if (w_match) begin
                        r_estado <= ABERTO;
                        r_aberto <= 1'b1;
                        r_tent   <= '0;
                        r_timer  <= CARGA_ABERTO;
                    end else begin
                        r_erro <= 1'b1;
                        r_tent <= w_tent_inc;
                        if (w_tent_inc == MAX_T) begin
                            r_estado <= BLOQUEADO;
                            r_bloq   <= 1'b1;
                            r_timer  <= CARGA_BLOQ;
                        end else begin
                            r_estado <= TRANCADO;
                        end
                    end
                end
                ABERTO: begin
                    if (w_expira) begin
                        r_estado <= TRANCADO;
                        r_aberto <= 1'b0;
                    end else if (w_evento) begin
                        r_aberto <= 1'b0;
                        if (modo_prog) begin
                            r_estado <= PROGRAMA;
                            r_timer  <= CARGA_ABERTO;
                        end else begin
                            r_estado <= TRANCADO;
                        end
                    end
                end
                PROGRAMA: begin
                    if (w_expira) begin
                        r_estado <= TRANCADO;
                    end else if (w_evento) begin
                        r_senha   <= codigo;
                        r_gravada <= 1'b1;
                        r_estado  <= TRANCADO;
                    end
                end
                BLOQUEADO: begin
                    if (w_expira) begin
                        r_estado <= TRANCADO;
                        r_bloq   <= 1'b0;
                        r_tent   <= '0;
                    end else if (w_mestre_blq) begin
                        r_estado <= ABERTO;
                        r_bloq   <= 1'b0;
                        r_aberto <= 1'b1;
                        r_tent   <= '0;
                        r_timer  <= CARGA_ABERTO;
                    end
                end
                default: begin
                    r_estado <= TRANCADO;
                    r_aberto <= 1'b0;
                    r_bloq   <= 1'b0;
                end
            endcase
        end
    end

    assign aberto        = r_aberto;
    assign bloqueado     = r_bloq;
    assign erro          = r_erro;
    assign senha_gravada = r_gravada;
    assign tentativas    = r_tent;
    assign estado        = r_estado;

endmodule
